// File: rtl/seq_mag_compare_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package seq_mag_compare_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RES_LT = 2'd0,
        RES_EQ = 2'd1,
        RES_GT = 2'd2
    } res_t;

    // Digit counter width; a single-digit compare still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/seq_mag_compare_digit_cmp.sv
// One-hot combinational compare of a single DIGIT-bit slice.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/seq_mag_compare.sv
// Digit-serial magnitude comparator, MSB digit first, early exit on first difference.
// Define SEQ_MAG_COMPARE_SIGNED_CMP_EN for two's-complement operands.
module seq_mag_compare
    import seq_mag_compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             d_lt;
    logic             d_eq;
    logic             d_gt;
    res_t             dres;

`ifdef SEQ_MAG_COMPARE_SIGNED_CMP_EN
    // Flipping the sign bit in both operands maps two's complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << (WIDTH - 1);
    assign a_in = A ^ SIGN_FLIP;
    assign b_in = B ^ SIGN_FLIP;
`else
    assign a_in = A;
    assign b_in = B;
`endif

    // The shadow registers shift left each step, so the active digit is always the top slice.
    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .lt (d_lt),
        .eq (d_eq),
        .gt (d_gt)
    );

    always_comb begin
        dres = RES_EQ;
        if (d_lt)
            dres = RES_LT;
        else if (d_gt)
            dres = RES_GT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        cnt     <= '0;
                        less    <= 1'b0;
                        equal   <= 1'b0;
                        greater <= 1'b0;
                        busy    <= 1'b1;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (dres != RES_EQ) begin
                        less    <= (dres == RES_LT);
                        greater <= (dres == RES_GT);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt == LAST) begin
                        equal   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        a_sh <= a_sh << DIGIT;
                        b_sh <= b_sh << DIGIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Randomized self-checking bench for seq_mag_compare: units 16/4, 8/1 and 8/8 against a plain-arithmetic model.
module tb_seq_mag_compare;

`ifdef SEQ_MAG_COMPARE_SIGNED_CMP_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    localparam int NU = 3;
    localparam int UW [NU] = '{16, 8, 8};
    localparam int UD [NU] = '{4, 1, 8};

    logic        clk;
    logic        rst;
    logic        start_v [NU];
    logic [15:0] a_v     [NU];
    logic [15:0] b_v     [NU];
    logic        busy_v  [NU];
    logic        done_v  [NU];
    logic        lt_v    [NU];
    logic        eq_v    [NU];
    logic        gt_v    [NU];

    int n_vec = 0;
    int n_err = 0;

    seq_mag_compare #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .less(lt_v[0]), .equal(eq_v[0]), .greater(gt_v[0])
    );
    seq_mag_compare #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1][7:0]), .B(b_v[1][7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .less(lt_v[1]), .equal(eq_v[1]), .greater(gt_v[1])
    );
    seq_mag_compare #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2][7:0]), .B(b_v[2][7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .less(lt_v[2]), .equal(eq_v[2]), .greater(gt_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {less, equal, greater} from integer order of the w-bit operands.
    function automatic logic [2:0] model_res(input int w, input logic [15:0] a, input logic [15:0] b);
        longint m, sa, sb;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (SGN) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        return {sa < sb, sa == sb, sa > sb};
    endfunction

    // Reference latency: 1-based index of the first differing digit from the MSB, else digit count.
    function automatic int model_lat(input int w, input int d, input logic [15:0] a, input logic [15:0] b);
        int n;
        longint da, db, dm;
        n  = w / d;
        dm = (longint'(1) << d) - 1;
        for (int i = 0; i < n; i++) begin
            da = (longint'(a) >> (w - (i + 1) * d)) & dm;
            db = (longint'(b) >> (w - (i + 1) * d)) & dm;
            if (da != db) return i + 1;
        end
        return n;
    endfunction

    function automatic logic [2:0] res_of(input int u);
        return {lt_v[u], eq_v[u], gt_v[u]};
    endfunction

    // Called at #1 after an edge; advances until done is seen, bounded.
    task automatic wait_done(input int u, inout int lat);
        while (done_v[u] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done_v[u] !== 1'b1) chk("done_timeout", 32'(lat), 32'hFFFF);
    endtask

    // Accept one compare, scramble the inputs right after, and return latency and result.
    task automatic do_cmp(input int u, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [2:0] res);
        a_v[u] = a;
        b_v[u] = b;
        start_v[u] = 1'b1;
        @(posedge clk); #1;
        start_v[u] = 1'b0;
        a_v[u] = 16'($urandom);
        b_v[u] = 16'($urandom);
        lat = 0;
        wait_done(u, lat);
        res = res_of(u);
    endtask

    task automatic check_cmp(input string tag, input int u, input logic [15:0] a, input logic [15:0] b);
        int lat;
        logic [2:0] res;
        do_cmp(u, a, b, lat, res);
        chk({tag, "_lat"}, 32'(lat), 32'(model_lat(UW[u], UD[u], a, b)));
        chk({tag, "_res"}, 32'(res), 32'(model_res(UW[u], a, b)));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(done_v[u]), 32'd0);
        chk({tag, "_hold"}, 32'(res_of(u)), 32'(model_res(UW[u], a, b)));
    endtask

    initial begin
        int lat;
        int seen;
        logic [2:0] res;
        logic [15:0] ra, rb;

        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            start_v[u] = 1'b0;
            a_v[u] = '0;
            b_v[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {27'd0, busy_v[0], done_v[0], res_of(0)}, 32'd0);
        rst = 1'b0;

        // Directed cases on the 16/4 unit, expected values written out by hand.
        do_cmp(0, 16'h5000, 16'h4000, lat, res);
        chk("gt_msd_lat", 32'(lat), 32'd1);
        chk("gt_msd_res", 32'(res), 32'b001);
        do_cmp(0, 16'h0001, 16'h0004, lat, res);
        chk("lt_lsd_lat", 32'(lat), 32'd4);
        chk("lt_lsd_res", 32'(res), 32'b100);
        @(posedge clk); #1;
        chk("lt_lsd_hold", {30'd0, done_v[0], lt_v[0]}, 32'b01);
        do_cmp(0, 16'h1234, 16'h1234, lat, res);
        chk("eq_lat", 32'(lat), 32'd4);
        chk("eq_res", 32'(res), 32'b010);
        do_cmp(0, 16'hFFFF, 16'h0001, lat, res);
        chk("ffff_lat", 32'(lat), 32'd1);
        chk("ffff_res", 32'(res), SGN ? 32'b100 : 32'b001);
        do_cmp(0, 16'h8000, 16'h7FFF, lat, res);
        chk("minmax_lat", 32'(lat), 32'd1);
        chk("minmax_res", 32'(res), SGN ? 32'b100 : 32'b001);

        // start while busy is ignored; then start in the done cycle is taken with no bubble.
        @(posedge clk); #1;
        a_v[0] = 16'h0001; b_v[0] = 16'h0004; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; lat = 0;
        @(posedge clk); #1;
        lat++;
        a_v[0] = 16'hFFFF; b_v[0] = 16'h0000; start_v[0] = 1'b1;
        @(posedge clk); #1;
        lat++;
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("busy_start_lat", 32'(lat), 32'd4);
        chk("busy_start_res", 32'(res_of(0)), 32'b100);
        a_v[0] = 16'h0300; b_v[0] = 16'h0200; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("b2b_accept", {30'd0, busy_v[0], done_v[0]}, 32'b10);
        lat = 0;
        wait_done(0, lat);
        chk("b2b_lat", 32'(lat), 32'd2);
        chk("b2b_res", 32'(res_of(0)), 32'b001);

        // Reset in the middle of a compare aborts it silently.
        @(posedge clk); #1;
        a_v[0] = 16'h1234; b_v[0] = 16'h1235; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        seen = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out", {27'd0, busy_v[0], done_v[0], res_of(0)}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1) seen++;
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        check_cmp("post_abort", 0, 16'h1234, 16'h1235);

        // Random sweep on all three geometries, biased toward long common prefixes.
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 30; i++) begin
                ra = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (16'd1 << $urandom_range(0, UW[u] - 1));
                    default: rb = 16'($urandom);
                endcase
                if (UW[u] == 8) begin
                    ra[15:8] = '0;
                    rb[15:8] = '0;
                end
                check_cmp($sformatf("rnd_u%0d", u), u, ra, rb);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
